// File: rtl/mmul_parallel_job_scheduler_pkg.sv
// Shared types and width helpers for the MMUL_PARALLEL job scheduler.
package mmul_parallel_sched_package;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

    // Queue entries are sized for the widest supported configuration; the top trims on read.
    localparam int SCHED_CORE_MAX_W   = 8;
    localparam int SCHED_JOB_ID_MAX_W = 32;

    typedef struct packed {
        logic [SCHED_CORE_MAX_W-1:0]   core;
        logic [SCHED_JOB_ID_MAX_W-1:0] job_id;
    } sched_entry_t;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mmul_parallel_job_scheduler_if.sv
// Core-side request/grant, engine start/done and status signals of the job scheduler.
interface mmul_parallel_job_scheduler_if #(
    parameter int N_CORES   = 2,
    parameter int N_CONTEXT = 2,
    parameter int JOB_ID_W  = 8
) ();
    localparam int CORE_W  = (N_CORES > 1) ? $clog2(N_CORES) : 1;
    localparam int LEVEL_W = $clog2(N_CONTEXT) + 1;

    logic                         clear_i;
    logic [N_CORES-1:0]           req_i;
    logic [N_CORES*JOB_ID_W-1:0]  job_id_i;
    logic [N_CORES-1:0]           gnt_o;
    logic                         start_o;
    logic [JOB_ID_W-1:0]          job_id_o;
    logic [CORE_W-1:0]            core_o;
    logic                         done_i;
    logic [N_CORES-1:0]           evt_o;
    logic                         busy_o;
    logic                         full_o;
    logic [LEVEL_W-1:0]           level_o;

    modport master (
        output clear_i, req_i, job_id_i, done_i,
        input  gnt_o, start_o, job_id_o, core_o, evt_o, busy_o, full_o, level_o
    );

    modport slave (
        input  clear_i, req_i, job_id_i, done_i,
        output gnt_o, start_o, job_id_o, core_o, evt_o, busy_o, full_o, level_o
    );

endinterface

// File: rtl/mmul_parallel_job_scheduler_rr_arbiter.sv
// Round-robin one-hot arbiter; the search starts at the pointer, which moves past each winner.
module mmul_parallel_rr_arbiter
    import mmul_parallel_sched_package::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = clog2_min1(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx
);
    logic [IDX_W-1:0] ptr_q;

    always_comb begin
        int   j;
        logic found;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        j       = 0;
        for (int i = 0; i < N; i++) begin
            j = (int'(ptr_q) + i) % N;
            if (en && !found && req[j]) begin
                gnt[j]  = 1'b1;
                gnt_idx = IDX_W'(j);
                found   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (clear) begin
            ptr_q <= '0;
        end else if (|gnt) begin
            ptr_q <= (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/mmul_parallel_job_scheduler.sv
// Shares one MMUL_PARALLEL engine between cores: RR arbitration, in-order job queue,
// and a start/run/done sequencer that signals completion back to the requesting core.
module mmul_parallel_job_scheduler
    import mmul_parallel_sched_package::*;
#(
    parameter int N_CORES   = 2,
    parameter int N_CONTEXT = 2,
    parameter int JOB_ID_W  = 8
) (
    input logic                          clk_i,
    input logic                          rst_i,
    mmul_parallel_job_scheduler_if.slave bus
);
    localparam int CORE_W  = clog2_min1(N_CORES);
    localparam int IDX_W   = $clog2(N_CONTEXT);
    localparam int LEVEL_W = IDX_W + 1;

    sched_state_t        state_q, state_d;
    sched_entry_t        mem [N_CONTEXT];
    logic [IDX_W-1:0]    rd_idx_q, wr_idx_q;
    logic [LEVEL_W-1:0]  level_q;
    logic [JOB_ID_W-1:0] job_id_q;
    logic [CORE_W-1:0]   core_q;
    logic [N_CORES-1:0]  gnt;
    logic [CORE_W-1:0]   gnt_idx;
    logic [N_CORES-1:0]  evt;
    logic                full, push, pop, arb_en, start, busy;

    assign full   = (level_q == LEVEL_W'(N_CONTEXT));
    // Reset is included so the combinational grant is also silent while rst_i is high.
    assign arb_en = !full && !bus.clear_i && !rst_i;
    assign push   = |gnt;
    assign pop    = (state_q == IDLE) && (level_q != '0) && !bus.clear_i;

    mmul_parallel_rr_arbiter #(
        .N     (N_CORES),
        .IDX_W (CORE_W)
    ) u_arb (
        .clk     (clk_i),
        .rst     (rst_i),
        .clear   (bus.clear_i),
        .en      (arb_en),
        .req     (bus.req_i),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_idx_q <= '0;
            wr_idx_q <= '0;
            level_q  <= '0;
        end else if (bus.clear_i) begin
            rd_idx_q <= '0;
            wr_idx_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_idx_q <= wr_idx_q + IDX_W'(1);
            if (pop)  rd_idx_q <= rd_idx_q + IDX_W'(1);
            if (push && !pop)      level_q <= level_q + LEVEL_W'(1);
            else if (pop && !push) level_q <= level_q - LEVEL_W'(1);
        end
    end

    // Payload storage needs no reset: entries are only read below the write index.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_idx_q] <= '{core:   SCHED_CORE_MAX_W'(gnt_idx),
                               job_id: SCHED_JOB_ID_MAX_W'(bus.job_id_i[gnt_idx*JOB_ID_W +: JOB_ID_W])};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            job_id_q <= '0;
            core_q   <= '0;
        end else if (bus.clear_i) begin
            job_id_q <= '0;
            core_q   <= '0;
        end else if (pop) begin
            job_id_q <= JOB_ID_W'(mem[rd_idx_q].job_id);
            core_q   <= CORE_W'(mem[rd_idx_q].core);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else if (bus.clear_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (level_q != '0) state_d = START;
            START:   state_d = RUN;
            RUN:     if (bus.done_i) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        start = 1'b0;
        busy  = 1'b0;
        evt   = '0;
        case (state_q)
            START: begin
                start = 1'b1;
                busy  = 1'b1;
            end
            RUN:  busy = 1'b1;
            DONE: begin
                busy = 1'b1;
                evt  = N_CORES'(1) << core_q;
            end
            default: ;
        endcase
    end

    assign bus.gnt_o    = gnt;
    assign bus.start_o  = start;
    assign bus.job_id_o = job_id_q;
    assign bus.core_o   = (N_CORES == 1) ? '0 : core_q;
    assign bus.evt_o    = evt;
    assign bus.busy_o   = busy;
    assign bus.full_o   = full;
    assign bus.level_o  = level_q;

endmodule

// File: tb/tb_mmul_parallel_job_scheduler.sv
// Directed bench for the MMUL_PARALLEL job scheduler with two cores and a two-entry queue.
module tb_mmul_parallel_job_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mmul_parallel_job_scheduler_if #(.N_CORES(2), .N_CONTEXT(2), .JOB_ID_W(8)) bus ();

    mmul_parallel_job_scheduler #(
        .N_CORES   (2),
        .N_CONTEXT (2),
        .JOB_ID_W  (8)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.clear_i  = 1'b0;
        bus.req_i    = 2'b01;
        bus.job_id_i = 16'h0000;
        bus.done_i   = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst_gnt",    32'(bus.gnt_o),    0);
        chk("rst_start",  32'(bus.start_o),  0);
        chk("rst_busy",   32'(bus.busy_o),   0);
        chk("rst_level",  32'(bus.level_o),  0);
        chk("rst_full",   32'(bus.full_o),   0);
        chk("rst_evt",    32'(bus.evt_o),    0);
        chk("rst_job_id", 32'(bus.job_id_o), 0);
        chk("rst_core",   32'(bus.core_o),   0);
        tick(); tick();
        rst = 1'b0;
        bus.req_i = 2'b00;

        // Single job from core 0
        tick();
        bus.req_i = 2'b01; bus.job_id_i = 16'h0011; #1;
        chk("single_gnt", 32'(bus.gnt_o), 32'h1);
        tick();
        bus.req_i = 2'b00; #1;
        chk("single_level_t1", 32'(bus.level_o), 1);
        chk("single_start_t1", 32'(bus.start_o), 0);
        tick();
        chk("single_start_t2", 32'(bus.start_o),  1);
        chk("single_job_id",   32'(bus.job_id_o), 32'h11);
        chk("single_core",     32'(bus.core_o),   0);
        chk("single_busy",     32'(bus.busy_o),   1);
        chk("single_level_t2", 32'(bus.level_o),  0);
        tick();
        chk("single_run_start", 32'(bus.start_o), 0);
        bus.done_i = 1'b1;
        tick();
        bus.done_i = 1'b0;
        chk("single_evt",      32'(bus.evt_o),  32'h1);
        chk("single_evt_busy", 32'(bus.busy_o), 1);
        tick();
        chk("single_evt_off", 32'(bus.evt_o),  0);
        chk("single_idle",    32'(bus.busy_o), 0);

        // Spurious done while IDLE
        bus.done_i = 1'b1;
        tick();
        bus.done_i = 1'b0;
        chk("spur_idle_busy", 32'(bus.busy_o), 0);
        chk("spur_idle_evt",  32'(bus.evt_o),  0);

        // Spurious done during START, then a real completion for core 1
        bus.req_i = 2'b10; bus.job_id_i = 16'h2200; #1;
        chk("spur_gnt", 32'(bus.gnt_o), 32'h2);
        tick();
        bus.req_i = 2'b00;
        tick();
        chk("spur_start",  32'(bus.start_o),  1);
        chk("spur_job_id", 32'(bus.job_id_o), 32'h22);
        chk("spur_core",   32'(bus.core_o),   1);
        bus.done_i = 1'b1;
        tick();
        bus.done_i = 1'b0;
        chk("spur_start_evt", 32'(bus.evt_o),   0);
        chk("spur_run_busy",  32'(bus.busy_o),  1);
        chk("spur_run_start", 32'(bus.start_o), 0);
        bus.done_i = 1'b1;
        tick();
        bus.done_i = 1'b0;
        chk("spur_real_evt", 32'(bus.evt_o), 32'h2);
        tick();
        chk("spur_end_busy", 32'(bus.busy_o), 0);

        // Both cores request continuously: alternation, FIFO order, full queue
        bus.req_i = 2'b11; bus.job_id_i = 16'hB0A0; #1;
        chk("rr_gnt0", 32'(bus.gnt_o), 32'h1);
        tick();
        bus.job_id_i = 16'hB0A1; #1;
        chk("rr_gnt1",  32'(bus.gnt_o),   32'h2);
        chk("rr_lvl1",  32'(bus.level_o), 1);
        tick();
        bus.job_id_i = 16'hB1A1; #1;
        chk("rr_start_a0", 32'(bus.start_o),  1);
        chk("rr_id_a0",    32'(bus.job_id_o), 32'hA0);
        chk("rr_core_a0",  32'(bus.core_o),   0);
        chk("rr_gnt2",     32'(bus.gnt_o),    32'h1);
        chk("rr_lvl2",     32'(bus.level_o),  1);
        tick();
        chk("full_level", 32'(bus.level_o), 2);
        chk("full_flag",  32'(bus.full_o),  1);
        chk("full_gnt",   32'(bus.gnt_o),   0);
        chk("full_busy",  32'(bus.busy_o),  1);
        bus.done_i = 1'b1;
        tick();
        bus.done_i = 1'b0;
        chk("full_evt",     32'(bus.evt_o),   32'h1);
        chk("full_gnt_dn",  32'(bus.gnt_o),   0);
        chk("full_lvl_dn",  32'(bus.level_o), 2);
        tick();
        chk("full_idle_evt", 32'(bus.evt_o),  0);
        chk("full_pop_gnt",  32'(bus.gnt_o),  0);
        chk("full_pop_flag", 32'(bus.full_o), 1);
        tick();
        chk("rr_start_b0", 32'(bus.start_o),  1);
        chk("rr_id_b0",    32'(bus.job_id_o), 32'hB0);
        chk("rr_core_b0",  32'(bus.core_o),   1);
        chk("free_level",  32'(bus.level_o),  1);
        chk("free_full",   32'(bus.full_o),   0);
        chk("free_gnt",    32'(bus.gnt_o),    32'h2);
        tick();
        chk("rr_lvl_run", 32'(bus.level_o), 2);

        // Clear during RUN with queued jobs; clear outranks push and done
        bus.clear_i = 1'b1; bus.done_i = 1'b1; #1;
        chk("clr_gnt", 32'(bus.gnt_o), 0);
        tick();
        bus.clear_i = 1'b0; bus.done_i = 1'b0; bus.req_i = 2'b00; #1;
        chk("clr_level",  32'(bus.level_o),  0);
        chk("clr_busy",   32'(bus.busy_o),   0);
        chk("clr_full",   32'(bus.full_o),   0);
        chk("clr_job_id", 32'(bus.job_id_o), 0);
        chk("clr_core",   32'(bus.core_o),   0);
        chk("clr_evt",    32'(bus.evt_o),    0);
        tick();
        chk("clr_no_start", 32'(bus.start_o), 0);
        bus.done_i = 1'b1;
        tick();
        bus.done_i = 1'b0;
        chk("clr_late_evt",  32'(bus.evt_o),  0);
        chk("clr_late_busy", 32'(bus.busy_o), 0);

        // Asynchronous reset during RUN (core 0 last granted, so pointer sits at 1)
        bus.req_i = 2'b01; bus.job_id_i = 16'h005C; #1;
        chk("ar_gnt", 32'(bus.gnt_o), 32'h1);
        tick();
        bus.req_i = 2'b00;
        tick();
        chk("ar_start", 32'(bus.start_o), 1);
        tick();
        chk("ar_run_busy", 32'(bus.busy_o),   1);
        chk("ar_run_id",   32'(bus.job_id_o), 32'h5C);
        bus.req_i = 2'b10;
        #3 rst = 1'b1;
        #1;
        chk("ar_busy",   32'(bus.busy_o),   0);
        chk("ar_start0", 32'(bus.start_o),  0);
        chk("ar_level",  32'(bus.level_o),  0);
        chk("ar_job_id", 32'(bus.job_id_o), 0);
        chk("ar_core",   32'(bus.core_o),   0);
        chk("ar_evt",    32'(bus.evt_o),    0);
        chk("ar_gnt0",   32'(bus.gnt_o),    0);
        tick();
        rst = 1'b0;
        bus.req_i = 2'b11; bus.job_id_i = 16'h8877; bus.done_i = 1'b1; #1;
        chk("ar_post_gnt", 32'(bus.gnt_o), 32'h1);
        tick();
        bus.req_i = 2'b00; bus.done_i = 1'b0; #1;
        chk("ar_post_lvl",  32'(bus.level_o), 1);
        chk("ar_post_evt",  32'(bus.evt_o),   0);
        chk("ar_post_busy", 32'(bus.busy_o),  0);
        tick();
        chk("ar_post_start", 32'(bus.start_o),  1);
        chk("ar_post_id",    32'(bus.job_id_o), 32'h77);
        chk("ar_post_core",  32'(bus.core_o),   0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
